// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Widths, polarities, FSM encodings and the IF/ID bundle.
package inst_fetch_pkg;

  localparam int AddrLen = 32;
  localparam int InstLen = 32;

  localparam logic [AddrLen-1:0] ZERO_WORD = '0;

  localparam logic True        = 1'b1;
  localparam logic False       = 1'b0;
  localparam logic ResetActive = 1'b0;

  typedef enum logic {
    IF_FETCH = 1'b0,
    IF_HOLD  = 1'b1
  } if_state_e;

  typedef struct packed {
    logic [AddrLen-1:0] pc;
    logic [InstLen-1:0] inst;
  } if_id_t;

  // Byte address of lane cnt of the word at pc; wraps mod 2^32.
  function automatic logic [AddrLen-1:0] lane_addr(
    input logic [AddrLen-1:0] pc,
    input logic [1:0]         cnt
  );
    return pc + {{(AddrLen-2){1'b0}}, cnt};
  endfunction

endpackage

// File: rtl/inst_assembler.sv
// Little-endian byte assembly buffer for one instruction word.
// Lanes 0..2 are latched; lane 3 is taken straight from din.
module inst_assembler
  import inst_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               we,
  input  logic [1:0]         sel,
  input  logic [7:0]         din,
  output logic [InstLen-1:0] word
);

  logic [2:0][7:0] lane_q;

  // Latch the acked byte into its lane, or drop the partial word.
  always_ff @(posedge clk) begin
    if (rst == ResetActive) begin
      lane_q <= '0;
    end else if (en) begin
      if (clr) begin
        lane_q <= '0;
      end else if (we) begin
        unique case (1'b1)
          sel == 2'd0: lane_q[0] <= din;
          sel == 2'd1: lane_q[1] <= din;
          sel == 2'd2: lane_q[2] <= din;
          sel == 2'd3: ;
        endcase
      end
    end
  end

  assign word = {din, lane_q[2], lane_q[1], lane_q[0]};

endmodule

// File: rtl/inst_fetch.sv
// RV32I fetch stage: builds each word from four byte reads
// and presents it to IF/ID, with stall and EX redirects.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [AddrLen-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               if_stall,
  input  logic               jmp_en,
  input  logic [AddrLen-1:0] jmp_target,
  output logic               mem_req,
  output logic [AddrLen-1:0] mem_addr,
  input  logic               mem_ack,
  input  logic [7:0]         mem_byte,
  output logic               if_valid,
  output logic [AddrLen-1:0] if_pc,
  output logic [InstLen-1:0] if_inst
);

  if_state_e          state_q;
  if_state_e          state_d;
  logic [1:0]         cnt_q;
  logic [AddrLen-1:0] pc_q;
  logic               valid_q;
  if_id_t             out_q;
  logic [InstLen-1:0] asm_word;

  logic in_fetch;
  logic ack_go;
  logic last_go;
  logic take_go;

  assign in_fetch = (state_q == IF_FETCH);
  assign ack_go   = !jmp_en && in_fetch && mem_ack;
  assign last_go  = ack_go && (cnt_q == 2'd3);
  assign take_go  = !jmp_en && !in_fetch && !if_stall;

  // State register; frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (rst == ResetActive) begin
      state_q <= IF_FETCH;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // Next state: redirect wins, then word done, then consume.
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      jmp_en:  state_d = IF_FETCH;
      last_go: state_d = IF_HOLD;
      take_go: state_d = IF_FETCH;
      default: ;
    endcase
  end

  // Memory request follows registered state only.
  always_comb begin
    mem_req  = False;
    mem_addr = lane_addr(pc_q, cnt_q);
    if (in_fetch) begin
      mem_req = True;
    end
  end

  // PC, byte counter and the presented IF/ID bundle.
  always_ff @(posedge clk) begin
    if (rst == ResetActive) begin
      pc_q    <= RESET_PC;
      cnt_q   <= 2'd0;
      valid_q <= False;
      out_q   <= '{pc: ZERO_WORD, inst: ZERO_WORD};
    end else if (rdy) begin
      if (jmp_en) begin
        pc_q    <= jmp_target;
        cnt_q   <= 2'd0;
        valid_q <= False;
      end else if (ack_go) begin
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          valid_q <= True;
          out_q   <= '{pc: pc_q, inst: asm_word};
          pc_q    <= pc_q + 32'd4;
        end
      end else if (take_go) begin
        valid_q <= False;
        cnt_q   <= 2'd0;
      end
    end
  end

  inst_assembler u_asm (
    .clk  (clk),
    .rst  (rst),
    .en   (rdy),
    .clr  (jmp_en | take_go),
    .we   (ack_go),
    .sel  (cnt_q),
    .din  (mem_byte),
    .word (asm_word)
  );

  assign if_valid = valid_q;
  assign if_pc    = out_q.pc;
  assign if_inst  = out_q.inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch with a zero-wait byte memory.
// Expected words are queued at fetch start, popped on if_valid.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        if_stall;
  logic        jmp_en;
  logic [31:0] jmp_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_byte;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  logic        ack_en;
  logic        corrupt;
  logic        prev_v;
  logic [63:0] sb[$];
  logic [63:0] e;
  int          n_cmp;
  int          n_bad;

  inst_fetch #(.RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .if_stall   (if_stall),
    .jmp_en     (jmp_en),
    .jmp_target (jmp_target),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_byte   (mem_byte),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(
    input logic [31:0] a
  );
    case (a)
      32'h0:   return 8'h13;
      32'h1:   return 8'h05;
      32'h2:   return 8'h10;
      32'h3:   return 8'h00;
      default: return a[7:0] ^ a[15:8]
                      ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(
    input logic [31:0] p
  );
    return {mem_rd(p + 32'd3), mem_rd(p + 32'd2),
            mem_rd(p + 32'd1), mem_rd(p)};
  endfunction

  assign mem_ack  = ack_en & mem_req;
  assign mem_byte = corrupt ? 8'hEE : mem_rd(mem_addr);

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch one word at p; optionally drop rdy for 2
  // cycles (with a bad byte on the bus) before lane pause.
  task automatic fetch_word(
    input logic [31:0] p,
    input int          pause
  );
    sb.push_back({p, exp_word(p)});
    for (int i = 0; i < 4; i++) begin
      if (i == pause) begin
        rdy     = 1'b0;
        corrupt = 1'b1;
        repeat (2) begin
          step();
          chk("rdy_addr", mem_addr, p + 32'(i));
          chk("rdy_req", mem_req, 1);
          chk("rdy_valid", if_valid, 0);
        end
        rdy     = 1'b1;
        corrupt = 1'b0;
      end
      chk("addr", mem_addr, p + 32'(i));
      step();
    end
    chk("valid", if_valid, 1);
  endtask

  // Scoreboard: pop one entry per new presentation.
  always @(negedge clk) begin
    if (if_valid && !prev_v) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_pc", if_pc, e[63:32]);
        chk("sb_inst", if_inst, e[31:0]);
      end
    end
    prev_v <= if_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    prev_v     = 1'b0;
    rst        = 1'b0;
    rdy        = 1'b1;
    if_stall   = 1'b0;
    jmp_en     = 1'b0;
    jmp_target = 32'h0;
    ack_en     = 1'b0;
    corrupt    = 1'b0;

    repeat (3) step();
    chk("rst_valid", if_valid, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_inst", if_inst, 0);
    chk("rst_addr", mem_addr, 0);
    rst    = 1'b1;
    ack_en = 1'b1;
    chk("boot_req", mem_req, 1);

    fetch_word(32'h0, 4);
    chk("first_inst", if_inst, 32'h0010_0513);

    if_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_req", mem_req, 0);
      chk("stall_valid", if_valid, 1);
      chk("stall_pc", if_pc, 0);
      chk("stall_inst", if_inst, 32'h0010_0513);
      step();
    end
    if_stall = 1'b0;
    step();
    chk("resume_addr", mem_addr, 32'h4);
    chk("resume_req", mem_req, 1);
    chk("resume_valid", if_valid, 0);

    fetch_word(32'h4, 4);
    step();
    chk("pc8_addr", mem_addr, 32'h8);
    step();
    step();
    ack_en     = 1'b0;
    jmp_en     = 1'b1;
    jmp_target = 32'h100;
    step();
    jmp_en = 1'b0;
    ack_en = 1'b1;
    chk("jmp_valid", if_valid, 0);
    fetch_word(32'h100, 4);
    step();

    repeat (3) step();
    jmp_en     = 1'b1;
    jmp_target = 32'h200;
    step();
    jmp_en = 1'b0;
    chk("jack_valid", if_valid, 0);
    chk("jack_addr", mem_addr, 32'h200);
    fetch_word(32'h200, 4);

    if_stall = 1'b1;
    step();
    chk("hjmp_held", if_valid, 1);
    jmp_en     = 1'b1;
    jmp_target = 32'h300;
    step();
    jmp_en = 1'b0;
    chk("hjmp_valid", if_valid, 0);
    chk("hjmp_req", mem_req, 1);
    chk("hjmp_addr", mem_addr, 32'h300);
    if_stall = 1'b0;
    fetch_word(32'h300, 4);
    step();

    fetch_word(32'h304, 2);

    jmp_en     = 1'b1;
    jmp_target = 32'hFFFF_FFFC;
    step();
    jmp_en = 1'b0;
    fetch_word(32'hFFFF_FFFC, 4);
    step();
    chk("wrap_addr", mem_addr, 32'h0);
    fetch_word(32'h0, 4);
    step();
    fetch_word(32'h4, 4);
    step();

    step();
    step();
    rst = 1'b0;
    step();
    chk("mrst_valid", if_valid, 0);
    chk("mrst_pc", if_pc, 0);
    chk("mrst_inst", if_inst, 0);
    chk("mrst_addr", mem_addr, 0);
    rst = 1'b1;
    fetch_word(32'h0, 4);
    step();
    chk("sb_drain", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
